ddr_para_unpacker: RTL
======================

# ddr_para_unpacker

Downstream consumer of the SD-to-DDR3 model-parameter path. After the parameter image has been copied from SD card into DDR3, this block drains the DDR3 read FIFO as 16-bit words and checks a one-word header. It packs payload word pairs into 32-bit parameter words and presents them, with a sequential address, on a valid/ready stream to the on-chip parameter buffers of the accelerator. It runs entirely in the system clock domain, the same domain as the DDR3 user read port.

## Interface
- MAGIC, 16'h5A5A, required value of the first (header) word of the stream
- CNT_W, 24, width of the payload word counter; matches the DDR max-address width
- ADDR_W, 20, width of the parameter output address
---
- sys_clk  in  1  system clock; one clock only
- sys_rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse: begin unpacking; honoured only in IDLE
- num_words  in  CNT_W  payload length in 16-bit words, header excluded; latched on accepted start
- rd_fifo_empty  in  1  DDR3 read FIFO empty flag
- rd_req  out  1  DDR3 read FIFO read enable
- rd_data  in  16  DDR3 read FIFO data, valid exactly 1 cycle after rd_req
- para_valid  out  1  para_data/para_addr valid
- para_ready  in  1  consumer accepts when para_valid & para_ready
- para_addr  out  ADDR_W  32-bit word index, starts at 0
- para_data  out  32  packed parameter word
- busy  out  1  high from accepted start until DONE/ERR
- done  out  1  sticky: all payload delivered
- hdr_err  out  1  sticky: header mismatch

## Operation
- States:
  - IDLE: waits for start.
  - HDR: reads 1 word and compares it with MAGIC.
  - DATA: streams the payload.
  - DONE: terminal.
  - ERR: terminal.
- IDLE --start--> HDR. On this transition, latch num_words, clear done/hdr_err, set busy, and zero the counters.
- HDR: issue one rd_req. When the word returns, go to DATA if it equals MAGIC, otherwise go to ERR (hdr_err=1, busy=0, no further rd_req).
- HDR with num_words==0 and a good header: go straight to DONE; no para output.
- DATA read rule: rd_req=1 only when all of the following hold:
  - rd_fifo_empty=0
  - no read in flight
  - requested payload count < latched num_words
  - output register free, i.e. !para_valid, or para_valid & para_ready this cycle
- Packing: the even-indexed payload word goes into the low-half holding register. The odd-indexed word forms para_data = {odd, even} and sets para_valid.
- Odd num_words: the final even word is emitted as {16'h0, word} once it is the last word.
- para_addr increments by 1 on each accepted transfer. Arithmetic wraps modulo 2^ADDR_W.
- DATA -> DONE when the last packed word is accepted (para_valid & para_ready). Then done=1 and busy=0.
- DONE/ERR -> HDR on a new start pulse; otherwise these states hold.
- start is ignored while busy.
- Reset mid-operation returns the block to IDLE and clears all outputs. Any in-flight rd_data is discarded. The FIFO is not flushed by this block.

## Timing
- Reset values: rd_req=0, para_valid=0, para_addr=0, para_data=0, busy=0, done=0, hdr_err=0; state IDLE.
- busy rises the cycle after start is sampled. First rd_req is possible the same cycle busy rises.
- FIFO read latency is fixed at 1. Data is captured on the cycle after rd_req. At most one read is in flight.
- Throughput: 1 read per 2 cycles, so one para word per 4 cycles with para_ready held high.
- para_valid stays high and para_data/para_addr stay stable until accepted. Holding para_ready low stalls rd_req.
- rd_fifo_empty going high: rd_req drops the same cycle (combinational gate). A read already in flight completes.
- done and hdr_err assert in the cycle after the final acceptance or the header compare, respectively.

## Test plan
- Nominal: header 5A5A, num_words=4, payload 0001,0002,0003,0004, para_ready=1 -> para {0002_0001}@0 then {0004_0003}@1, then done=1, busy=0.
- Odd length: num_words=3, payload 1111,2222,3333 -> {2222_1111}@0, {0000_3333}@1, done.
- Bad header: first word 1234 -> hdr_err=1, zero para_valid, no rd_req after the header read, busy=0.
- Backpressure/empty: para_ready low for 10 cycles and rd_fifo_empty toggling -> para_data/para_addr hold, no rd_req while stalled or empty, no word lost or duplicated over num_words=64.
- Reset mid-stream: assert sys_rst_n=0 after 3 para words -> all outputs 0 immediately. After release and a new start with a fresh image, the address restarts at 0.
- Zero length and re-start: num_words=0 -> done with no para. A start pulse while busy is ignored. A start in DONE reruns correctly.

Source files
------------

// File: rtl/ddr_para_unpacker.sv
// Drains the DDR3 read FIFO as 16-bit words, checks the header word and packs
// payload pairs into addressed 32-bit parameter words on a valid/ready stream.
module ddr_para_unpacker #(
  parameter logic [15:0] MAGIC  = 16'h5A5A,
  parameter int          CNT_W  = 24,
  parameter int          ADDR_W = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              rd_fifo_empty,
  output logic              rd_req,
  input  logic [15:0]       rd_data,
  output logic              para_valid,
  input  logic              para_ready,
  output logic [ADDR_W-1:0] para_addr,
  output logic [31:0]       para_data,
  output logic              busy,
  output logic              done,
  output logic              hdr_err
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] rcv_cnt;
  logic [15:0]      low_q;
  logic             in_flight;
  logic             hdr_sent;
  logic             accept;
  logic             out_free;
  logic             last_word;

  assign accept    = para_valid & para_ready;
  assign out_free  = !para_valid | para_ready;
  assign last_word = (rcv_cnt == words_q - 1'b1);

  // Read enable is combinational so a rising empty flag gates it the same cycle.
  always_comb begin
    rd_req = 1'b0;
    if (!rd_fifo_empty && !in_flight) begin
      if (state == HDR)
        rd_req = !hdr_sent;
      else if (state == DATA)
        rd_req = (req_cnt < words_q) && out_free;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      words_q    <= '0;
      req_cnt    <= '0;
      rcv_cnt    <= '0;
      low_q      <= '0;
      in_flight  <= 1'b0;
      hdr_sent   <= 1'b0;
      para_valid <= 1'b0;
      para_addr  <= '0;
      para_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hdr_err    <= 1'b0;
    end else begin
      in_flight <= rd_req;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= HDR;
            words_q   <= num_words;
            req_cnt   <= '0;
            rcv_cnt   <= '0;
            para_addr <= '0;
            hdr_sent  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            hdr_err   <= 1'b0;
          end
        end
        HDR: begin
          if (rd_req)
            hdr_sent <= 1'b1;
          if (in_flight) begin
            if (rd_data != MAGIC) begin
              state   <= ERR;
              hdr_err <= 1'b1;
              busy    <= 1'b0;
            end else if (words_q == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (rd_req)
            req_cnt <= req_cnt + 1'b1;
          // All words already received means this acceptance drains the stream.
          if (accept) begin
            para_valid <= 1'b0;
            para_addr  <= para_addr + 1'b1;
            if (rcv_cnt == words_q) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          if (in_flight) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (!rcv_cnt[0]) begin
              low_q <= rd_data;
              if (last_word) begin
                para_data  <= {16'h0000, rd_data};
                para_valid <= 1'b1;
              end
            end else begin
              para_data  <= {rd_data, low_q};
              para_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
